integer_reservation_station: RTL and testbench

//  Reservation station in front of the integer lane: holds renamed integer ops until both

---
 rtl/integer_reservation_station_if.sv | 51 +++++
 rtl/integer_reservation_station.sv | 179 +++++++++++++++++
 tb/tb_integer_reservation_station.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/integer_reservation_station_if.sv
// Issue, CDB, dispatch and flush signals of the integer reservation station.
// slave: the station itself; master: rename/CDB/integer-lane side.
interface integer_reservation_station_if #(
    parameter int XLEN                = 64,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int DECODED_INSTR_WIDTH = 6
);
    logic                           issue_valid;
    logic                           issue_ready;
    logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction;
    logic [ROB_INDEX_WIDTH-1:0]     issue_ROB_index;
    logic [XLEN-1:0]                issue_PC;
    logic                           issue_1st_ready;
    logic                           issue_2nd_ready;
    logic [XLEN-1:0]                issue_1st_value;
    logic [XLEN-1:0]                issue_2nd_value;
    logic [ROB_INDEX_WIDTH-1:0]     issue_1st_tag;
    logic [ROB_INDEX_WIDTH-1:0]     issue_2nd_tag;

    logic                           cdb_valid;
    logic [ROB_INDEX_WIDTH-1:0]     cdb_ROB_index;
    logic [XLEN-1:0]                cdb_value;

    logic                           dispatch_valid;
    logic                           dispatch_ready;
    logic [XLEN-1:0]                dispatch_1st_reg;
    logic [XLEN-1:0]                dispatch_2nd_reg;
    logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction;
    logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index;
    logic [XLEN-1:0]                dispatch_PC_i;

    logic                           flush;

    modport master (
        output issue_valid, issue_decoded_instruction, issue_ROB_index, issue_PC,
               issue_1st_ready, issue_2nd_ready, issue_1st_value, issue_2nd_value,
               issue_1st_tag, issue_2nd_tag,
               cdb_valid, cdb_ROB_index, cdb_value, dispatch_ready, flush,
        input  issue_ready, dispatch_valid, dispatch_1st_reg, dispatch_2nd_reg,
               dispatch_decoded_instruction, dispatch_ROB_index, dispatch_PC_i
    );

    modport slave (
        input  issue_valid, issue_decoded_instruction, issue_ROB_index, issue_PC,
               issue_1st_ready, issue_2nd_ready, issue_1st_value, issue_2nd_value,
               issue_1st_tag, issue_2nd_tag,
               cdb_valid, cdb_ROB_index, cdb_value, dispatch_ready, flush,
        output issue_ready, dispatch_valid, dispatch_1st_reg, dispatch_2nd_reg,
               dispatch_decoded_instruction, dispatch_ROB_index, dispatch_PC_i
    );
endinterface

// File: rtl/integer_reservation_station.sv
// Integer reservation station: holds renamed ops, snoops the CDB, dispatches one ready op/cycle.
// Define RS_AGE_ORDER_EN for oldest-first select; otherwise lowest-index ready slot wins.
module integer_reservation_station #(
    parameter int XLEN                = 64,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int DECODED_INSTR_WIDTH = 6,
    parameter int NUM_SLOTS           = 4
) (
    input logic                          clock,
    input logic                          reset,
    integer_reservation_station_if.slave bus
);
    localparam int AW = $clog2(NUM_SLOTS);

    typedef struct packed {
        logic                           valid;
        logic [DECODED_INSTR_WIDTH-1:0] op;
        logic [ROB_INDEX_WIDTH-1:0]     rob;
        logic [XLEN-1:0]                pc;
        logic                           rdy1;
        logic [XLEN-1:0]                val1;
        logic [ROB_INDEX_WIDTH-1:0]     tag1;
        logic                           rdy2;
        logic [XLEN-1:0]                val2;
        logic [ROB_INDEX_WIDTH-1:0]     tag2;
    } slot_t;

    slot_t         slots      [NUM_SLOTS];
    slot_t         slots_next [NUM_SLOTS];
    logic [AW-1:0] free_idx;
    logic [AW-1:0] sel_idx;
    logic          has_free;
    logic          any_cand;
    logic          issue_fire;
    logic          dispatch_fire;
    logic          hit1;
    logic          hit2;

`ifdef RS_AGE_ORDER_EN
    logic [AW-1:0] age      [NUM_SLOTS];
    logic [AW-1:0] age_next [NUM_SLOTS];
    logic [AW-1:0] best_age;
    logic [AW-1:0] live_count;
`endif

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!slots[i].valid && !has_free) begin
                has_free = 1'b1;
                free_idx = AW'(i);
            end
        end
    end

    always_comb begin
        any_cand = 1'b0;
        sel_idx  = '0;
`ifdef RS_AGE_ORDER_EN
        best_age = '1;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slots[i].valid && slots[i].rdy1 && slots[i].rdy2 &&
                (!any_cand || age[i] < best_age)) begin
                any_cand = 1'b1;
                sel_idx  = AW'(i);
                best_age = age[i];
            end
        end
`else
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slots[i].valid && slots[i].rdy1 && slots[i].rdy2 && !any_cand) begin
                any_cand = 1'b1;
                sel_idx  = AW'(i);
            end
        end
`endif
    end

    assign issue_fire    = bus.issue_valid && has_free;
    assign dispatch_fire = any_cand && bus.dispatch_ready;
    assign hit1 = bus.cdb_valid && (bus.cdb_ROB_index == bus.issue_1st_tag);
    assign hit2 = bus.cdb_valid && (bus.cdb_ROB_index == bus.issue_2nd_tag);

    // Wakeup, dispatch-clear and issue-write touch distinct slots, so one pass covers all three.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slots_next[i] = slots[i];
            if (slots[i].valid && !slots[i].rdy1 && bus.cdb_valid &&
                bus.cdb_ROB_index == slots[i].tag1) begin
                slots_next[i].rdy1 = 1'b1;
                slots_next[i].val1 = bus.cdb_value;
            end
            if (slots[i].valid && !slots[i].rdy2 && bus.cdb_valid &&
                bus.cdb_ROB_index == slots[i].tag2) begin
                slots_next[i].rdy2 = 1'b1;
                slots_next[i].val2 = bus.cdb_value;
            end
            if (dispatch_fire && sel_idx == AW'(i)) begin
                slots_next[i] = '0;
            end
            if (issue_fire && free_idx == AW'(i)) begin
                slots_next[i].valid = 1'b1;
                slots_next[i].op    = bus.issue_decoded_instruction;
                slots_next[i].rob   = bus.issue_ROB_index;
                slots_next[i].pc    = bus.issue_PC;
                slots_next[i].tag1  = bus.issue_1st_tag;
                slots_next[i].tag2  = bus.issue_2nd_tag;
                slots_next[i].rdy1  = bus.issue_1st_ready || hit1;
                slots_next[i].rdy2  = bus.issue_2nd_ready || hit2;
                slots_next[i].val1  = bus.issue_1st_ready ? bus.issue_1st_value :
                                      (hit1 ? bus.cdb_value : '0);
                slots_next[i].val2  = bus.issue_2nd_ready ? bus.issue_2nd_value :
                                      (hit2 ? bus.cdb_value : '0);
            end
        end
    end

`ifdef RS_AGE_ORDER_EN
    // New op's age is the number of slots that stay valid across this edge.
    always_comb begin
        live_count = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slots[i].valid && !(dispatch_fire && sel_idx == AW'(i))) begin
                live_count = live_count + AW'(1);
            end
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            age_next[i] = age[i];
            if (dispatch_fire && slots[i].valid && age[i] > age[sel_idx]) begin
                age_next[i] = age[i] - AW'(1);
            end
            if (dispatch_fire && sel_idx == AW'(i)) begin
                age_next[i] = '0;
            end
            if (issue_fire && free_idx == AW'(i)) begin
                age_next[i] = live_count;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) age[i] <= '0;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) age[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) age[i] <= age_next[i];
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= slots_next[i];
        end
    end

    always_comb begin
        bus.issue_ready                  = has_free;
        bus.dispatch_valid               = any_cand;
        bus.dispatch_1st_reg             = '0;
        bus.dispatch_2nd_reg             = '0;
        bus.dispatch_decoded_instruction = '0;
        bus.dispatch_ROB_index           = '0;
        bus.dispatch_PC_i                = '0;
        if (any_cand) begin
            bus.dispatch_1st_reg             = slots[sel_idx].val1;
            bus.dispatch_2nd_reg             = slots[sel_idx].val2;
            bus.dispatch_decoded_instruction = slots[sel_idx].op;
            bus.dispatch_ROB_index           = slots[sel_idx].rob;
            bus.dispatch_PC_i                = slots[sel_idx].pc;
        end
    end
endmodule

// File: tb/tb_integer_reservation_station.sv
// Scoreboard bench for integer_reservation_station: directed issue/CDB/flush/reset vectors,
// expected dispatches queued at issue time and compared by a negedge monitor.
module tb_integer_reservation_station;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    integer_reservation_station_if #(
        .XLEN(64), .ROB_INDEX_WIDTH(8), .DECODED_INSTR_WIDTH(6)
    ) bus ();

    integer_reservation_station #(
        .XLEN(64), .ROB_INDEX_WIDTH(8), .DECODED_INSTR_WIDTH(6), .NUM_SLOTS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  rob;
        logic [63:0] pc;
        logic [63:0] v1;
        logic [63:0] v2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        if (reset && bus.dispatch_valid && bus.dispatch_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dispatch: got rob 0x%0h, expected no dispatch",
                         bus.dispatch_ROB_index);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("disp_rob", 64'(bus.dispatch_ROB_index), 64'(e.rob));
                check("disp_op",  64'(bus.dispatch_decoded_instruction), 64'(e.op));
                check("disp_pc",  bus.dispatch_PC_i, e.pc);
                check("disp_1st", bus.dispatch_1st_reg, e.v1);
                check("disp_2nd", bus.dispatch_2nd_reg, e.v2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [7:0] rob, input logic [63:0] pc,
                             input logic r1, input logic [63:0] v1, input logic [7:0] t1,
                             input logic r2, input logic [63:0] v2, input logic [7:0] t2);
        bus.issue_valid               = 1'b1;
        bus.issue_decoded_instruction = op;
        bus.issue_ROB_index           = rob;
        bus.issue_PC                  = pc;
        bus.issue_1st_ready           = r1;
        bus.issue_1st_value           = v1;
        bus.issue_1st_tag             = t1;
        bus.issue_2nd_ready           = r2;
        bus.issue_2nd_value           = v2;
        bus.issue_2nd_tag             = t2;
    endtask

    task automatic set_cdb(input logic [7:0] tag, input logic [63:0] val);
        bus.cdb_valid     = 1'b1;
        bus.cdb_ROB_index = tag;
        bus.cdb_value     = val;
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [7:0] rob, input logic [63:0] pc,
                            input logic [63:0] v1, input logic [63:0] v2);
        exp_t e;
        e.op = op; e.rob = rob; e.pc = pc; e.v1 = v1; e.v2 = v2;
        sb.push_back(e);
    endtask

    task automatic drained(input string name);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        idle();
        bus.dispatch_ready = 1'b1;
        set_issue(6'd0, 8'd0, 64'd0, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0, 8'd0);
        bus.issue_valid = 1'b0;
        set_cdb(8'd0, 64'd0);
        bus.cdb_valid = 1'b0;

        // Reset state
        #3;
        check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
        check("rst_dispatch_valid", 64'(bus.dispatch_valid), 64'd0);
        check("rst_1st_reg", bus.dispatch_1st_reg, 64'd0);
        check("rst_rob", 64'(bus.dispatch_ROB_index), 64'd0);
        #9 reset = 1'b1;
        step();

        // 1: both operands ready
        push_exp(6'd0, 8'd3, 64'h100, 64'd5, 64'd7);
        set_issue(6'd0, 8'd3, 64'h100, 1'b1, 64'd5, 8'd0, 1'b1, 64'd7, 8'd0);
        mid();
        check("t1_no_same_cycle", 64'(bus.dispatch_valid), 64'd0);
        step(); idle(); mid();
        check("t1_dispatch_valid", 64'(bus.dispatch_valid), 64'd1);
        step(); mid();
        check("t1_freed", 64'(bus.dispatch_valid), 64'd0);
        check("t1_issue_ready", 64'(bus.issue_ready), 64'd1);
        step();
        drained("t1_drained");

        // 2: 2nd operand waits on tag 9; wrong tag 8 first
        push_exp(6'd1, 8'd4, 64'h200, 64'h11, 64'h20);
        set_issue(6'd1, 8'd4, 64'h200, 1'b1, 64'h11, 8'd0, 1'b0, 64'd0, 8'd9);
        step(); idle(); set_cdb(8'd8, 64'h99); mid();
        check("t2_waiting", 64'(bus.dispatch_valid), 64'd0);
        step(); set_cdb(8'd9, 64'h20); mid();
        check("t2_wrong_tag", 64'(bus.dispatch_valid), 64'd0);
        step(); idle(); mid();
        check("t2_woken", 64'(bus.dispatch_valid), 64'd1);
        check("t2_2nd_value", bus.dispatch_2nd_reg, 64'h20);
        step(); mid();
        check("t2_freed", 64'(bus.dispatch_valid), 64'd0);
        step();
        drained("t2_drained");

        // 3: CDB hit in the issue cycle
        push_exp(6'd2, 8'd5, 64'h300, 64'h33, 64'h44);
        set_issue(6'd2, 8'd5, 64'h300, 1'b0, 64'd0, 8'd9, 1'b1, 64'h44, 8'd0);
        set_cdb(8'd9, 64'h33);
        mid();
        check("t3_no_same_cycle", 64'(bus.dispatch_valid), 64'd0);
        step(); idle(); mid();
        check("t3_captured", 64'(bus.dispatch_valid), 64'd1);
        step(); mid();
        check("t3_freed", 64'(bus.dispatch_valid), 64'd0);
        step();
        drained("t3_drained");

        // 4: fill while stalled, 5th issue ignored, then drain
        bus.dispatch_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(6'd3, 8'(10 + i), 64'(64'h400 + i * 4), 1'b1, 64'(i + 1), 8'd0,
                      1'b1, 64'((i + 1) * 2), 8'd0);
            step();
        end
        idle(); mid();
        check("t4_full_issue_ready", 64'(bus.issue_ready), 64'd0);
        check("t4_dispatch_valid", 64'(bus.dispatch_valid), 64'd1);
        check("t4_sel_rob", 64'(bus.dispatch_ROB_index), 64'd10);
        step();
        set_issue(6'd3, 8'd14, 64'h500, 1'b1, 64'd9, 8'd0, 1'b1, 64'd9, 8'd0);
        mid();
        check("t4_hold_rob_a", 64'(bus.dispatch_ROB_index), 64'd10);
        step(); idle(); mid();
        check("t4_hold_rob_b", 64'(bus.dispatch_ROB_index), 64'd10);
        check("t4_hold_1st", bus.dispatch_1st_reg, 64'd1);
        check("t4_still_full", 64'(bus.issue_ready), 64'd0);
        for (int i = 0; i < 4; i++)
            push_exp(6'd3, 8'(10 + i), 64'(64'h400 + i * 4), 64'(i + 1), 64'((i + 1) * 2));
        step();
        bus.dispatch_ready = 1'b1;
        mid();
        step(); mid();
        check("t4_issue_ready_after_first", 64'(bus.issue_ready), 64'd1);
        step(); mid();
        step(); mid();
        step(); mid();
        check("t4_empty", 64'(bus.dispatch_valid), 64'd0);
        step();
        drained("t4_drained");

        // 5: older waiting op in slot 1, younger ready op in slot 0
        bus.dispatch_ready = 1'b0;
        set_issue(6'd4, 8'd19, 64'h600, 1'b1, 64'h1, 8'd0, 1'b1, 64'h2, 8'd0);
        step();
        set_issue(6'd5, 8'd20, 64'h610, 1'b0, 64'd0, 8'd1, 1'b1, 64'h3, 8'd0);
        step(); idle();
        push_exp(6'd4, 8'd19, 64'h600, 64'h1, 64'h2);
        bus.dispatch_ready = 1'b1;
        mid();
        step();
        bus.dispatch_ready = 1'b0;
        set_issue(6'd6, 8'd21, 64'h620, 1'b1, 64'h7, 8'd0, 1'b1, 64'h8, 8'd0);
        step(); idle(); set_cdb(8'd1, 64'h55); mid();
        check("t5_only_b_ready", 64'(bus.dispatch_ROB_index), 64'd21);
        step(); idle();
`ifdef RS_AGE_ORDER_EN
        push_exp(6'd5, 8'd20, 64'h610, 64'h55, 64'h3);
        push_exp(6'd6, 8'd21, 64'h620, 64'h7, 64'h8);
`else
        push_exp(6'd6, 8'd21, 64'h620, 64'h7, 64'h8);
        push_exp(6'd5, 8'd20, 64'h610, 64'h55, 64'h3);
`endif
        bus.dispatch_ready = 1'b1;
        mid();
        step(); mid();
        step(); mid();
        check("t5_empty", 64'(bus.dispatch_valid), 64'd0);
        step();
        drained("t5_drained");

        // 6: flush with concurrent issue, then reset mid-wakeup
        bus.dispatch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_issue(6'd7, 8'(30 + i), 64'(64'h680 + i), 1'b1, 64'd1, 8'd0, 1'b1, 64'd2, 8'd0);
            step();
        end
        set_issue(6'd7, 8'd33, 64'h690, 1'b1, 64'd1, 8'd0, 1'b1, 64'd2, 8'd0);
        bus.flush = 1'b1;
        mid();
        check("t6_pre_flush_valid", 64'(bus.dispatch_valid), 64'd1);
        step(); idle(); mid();
        check("t6_flush_dispatch_valid", 64'(bus.dispatch_valid), 64'd0);
        check("t6_flush_issue_ready", 64'(bus.issue_ready), 64'd1);
        check("t6_flush_1st_reg", bus.dispatch_1st_reg, 64'd0);
        step();
        bus.dispatch_ready = 1'b1;
        mid();
        check("t6_flush_nothing_left", 64'(bus.dispatch_valid), 64'd0);
        step();
        bus.dispatch_ready = 1'b0;
        set_issue(6'd8, 8'd40, 64'h700, 1'b1, 64'hAA, 8'd0, 1'b1, 64'hBB, 8'd0);
        step();
        set_issue(6'd8, 8'd41, 64'h710, 1'b0, 64'd0, 8'd7, 1'b1, 64'd1, 8'd0);
        step(); idle(); set_cdb(8'd7, 64'h77);
        #2;
        check("t6_pre_reset_valid", 64'(bus.dispatch_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("t6_reset_dispatch_valid", 64'(bus.dispatch_valid), 64'd0);
        check("t6_reset_1st_reg", bus.dispatch_1st_reg, 64'd0);
        check("t6_reset_rob", 64'(bus.dispatch_ROB_index), 64'd0);
        check("t6_reset_issue_ready", 64'(bus.issue_ready), 64'd1);
        idle();
        @(negedge clock);
        reset = 1'b1;
        step();
        bus.dispatch_ready = 1'b1;
        mid();
        check("t6_after_reset_empty", 64'(bus.dispatch_valid), 64'd0);
        step();
        drained("final_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
